// File: rtl/keypad_pkg.sv
// Shared types and BCD HH:MM validation for the keypad time-entry path.
// Pure declarations; no latency and no backpressure.
package keypad_pkg;

  localparam logic [3:0]  BCD_BLANK         = 4'ha;
  localparam logic [15:0] KEYPAD_BLANK_WORD = 16'haaaa;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    COMMIT  = 3'd3,
    FAIL    = 3'd4
  } state_e;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_e;

  function automatic logic bcd_hhmm_valid(input logic [15:0] word, input logic mode24);
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic       ok;
    h1 = word[15:12];
    h0 = word[11:8];
    m1 = word[7:4];
    m0 = word[3:0];
    // Real digits are 0-9, which is exactly "below the blank code".
    ok = (h1 < BCD_BLANK) && (h0 < BCD_BLANK) && (m1 < BCD_BLANK) &&
         (m0 < BCD_BLANK) && (m1 <= 4'd5);
    if (mode24) begin
      ok = ok && (h1 <= 4'd2) && !((h1 == 4'd2) && (h0 > 4'd3));
    end else begin
      ok = ok && (((h1 == 4'd0) && (h0 != 4'd0)) || ((h1 == 4'd1) && (h0 <= 4'd2)));
    end
    return ok;
  endfunction

endpackage

// File: rtl/keypad_time_loader_sync.sv
// Synchronizes the asynchronous keypad shift indication and emits one pulse per rising edge.
// Latency SYNC_STAGES+1 cycles from input rise to digit_evt; no backpressure.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic digit_evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   last_q;
  logic                   last_d;
  logic                   evt_q;
  logic                   evt_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    last_d = sync_q[SYNC_STAGES-1];
    evt_d  = sync_q[SYNC_STAGES-1] & ~last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      evt_q  <= evt_d;
    end
  end

  assign digit_evt = evt_q;

endmodule

// File: rtl/keypad_time_loader.sv
// Arms the keypad, counts four digits, validates HH:MM and commits it to the clock or alarm.
// Strobe 2 cycles after the 4th digit event; requests while busy are dropped, never queued.
module keypad_time_loader import keypad_pkg::*; #(
  parameter int HOUR_MODE_24   = 1,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keypad_values,
  input  logic        shift_pulse,
  input  logic        load_time_req,
  input  logic        load_alarm_req,
  input  logic        cancel,
  output logic        reset_shift,
  output logic        time_load,
  output logic        alarm_load,
  output logic [15:0] load_value,
  output logic        entry_error,
  output logic        busy,
  output logic [2:0]  digit_count
);

  localparam int             TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic rst_meta_q;
  logic rst_sync_q;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic digit_evt;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_sync_q),
    .async_in (shift_pulse),
    .digit_evt(digit_evt)
  );

  state_e        state_q,       state_d;
  target_e       target_q,      target_d;
  logic [2:0]    count_q,       count_d;
  logic [TW-1:0] timer_q,       timer_d;
  logic [15:0]   load_value_q,  load_value_d;
  logic          reset_shift_q, reset_shift_d;
  logic          time_load_q,   time_load_d;
  logic          alarm_load_q,  alarm_load_d;
  logic          entry_error_q, entry_error_d;
  logic          word_ok;

  assign word_ok = bcd_hhmm_valid(keypad_values, HOUR_MODE_24 != 0);

  // Pulse outputs are registered on entry to the state that owns them,
  // so the strobe and load_value change together.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    count_d       = count_q;
    timer_d       = timer_q;
    load_value_d  = load_value_q;
    reset_shift_d = 1'b0;
    time_load_d   = 1'b0;
    alarm_load_d  = 1'b0;
    entry_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_time_req || load_alarm_req) begin
          target_d      = load_time_req ? TGT_TIME : TGT_ALARM;
          reset_shift_d = 1'b1;
          count_d       = 3'd0;
          timer_d       = '0;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          reset_shift_d = 1'b1;
          state_d       = IDLE;
        end else if (digit_evt) begin
          timer_d = '0;
          count_d = (count_q >= 3'd4) ? 3'd4 : count_q + 3'd1;
          if (count_q >= 3'd3) begin
            state_d = CHECK;
          end
        end else if (timer_q == TIMER_LAST) begin
          entry_error_d = 1'b1;
          reset_shift_d = 1'b1;
          state_d       = FAIL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        reset_shift_d = 1'b1;
        if (word_ok) begin
          load_value_d = keypad_values;
          time_load_d  = (target_q == TGT_TIME);
          alarm_load_d = (target_q == TGT_ALARM);
          state_d      = COMMIT;
        end else begin
          entry_error_d = 1'b1;
          state_d       = FAIL;
        end
      end
      COMMIT:  state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q       <= IDLE;
      target_q      <= TGT_TIME;
      count_q       <= 3'd0;
      timer_q       <= '0;
      load_value_q  <= 16'h0000;
      reset_shift_q <= 1'b0;
      time_load_q   <= 1'b0;
      alarm_load_q  <= 1'b0;
      entry_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      load_value_q  <= load_value_d;
      reset_shift_q <= reset_shift_d;
      time_load_q   <= time_load_d;
      alarm_load_q  <= alarm_load_d;
      entry_error_q <= entry_error_d;
    end
  end

  assign reset_shift = reset_shift_q;
  assign time_load   = time_load_q;
  assign alarm_load  = alarm_load_q;
  assign load_value  = load_value_q;
  assign entry_error = entry_error_q;
  assign busy        = (state_q != IDLE);
  assign digit_count = count_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Directed bench: a 24h and a 12h instance share the same keypad stimulus.
module tb_keypad_time_loader;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] keypad_values = KEYPAD_BLANK_WORD;
  logic        shift_pulse = 1'b0;
  logic        load_time_req = 1'b0;
  logic        load_alarm_req = 1'b0;
  logic        cancel = 1'b0;

  logic        a_rs, a_tl, a_al, a_err, a_busy;
  logic [15:0] a_lv;
  logic [2:0]  a_dc;
  logic        b_rs, b_tl, b_al, b_err, b_busy;
  logic [15:0] b_lv;
  logic [2:0]  b_dc;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  keypad_time_loader #(.HOUR_MODE_24(1), .TIMEOUT_CYCLES(20), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .reset_n(reset_n), .keypad_values(keypad_values), .shift_pulse(shift_pulse),
    .load_time_req(load_time_req), .load_alarm_req(load_alarm_req), .cancel(cancel),
    .reset_shift(a_rs), .time_load(a_tl), .alarm_load(a_al), .load_value(a_lv),
    .entry_error(a_err), .busy(a_busy), .digit_count(a_dc));

  keypad_time_loader #(.HOUR_MODE_24(0), .TIMEOUT_CYCLES(20), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .reset_n(reset_n), .keypad_values(keypad_values), .shift_pulse(shift_pulse),
    .load_time_req(load_time_req), .load_alarm_req(load_alarm_req), .cancel(cancel),
    .reset_shift(b_rs), .time_load(b_tl), .alarm_load(b_al), .load_value(b_lv),
    .entry_error(b_err), .busy(b_busy), .digit_count(b_dc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle where the DUT's digit_evt is high.
  task automatic send_digit(input logic [15:0] kv);
    keypad_values = kv;
    tick();
    shift_pulse = 1'b1;
    repeat (3) tick();
    shift_pulse = 1'b0;
  endtask

  task automatic enter_digits(input logic [15:0] w, input int n);
    logic [15:0] kv;
    kv = KEYPAD_BLANK_WORD;
    for (int i = 0; i < n; i++) begin
      kv = {kv[11:0], w[15-4*i -: 4]};
      send_digit(kv);
    end
  endtask

  task automatic request(input logic t, input logic a);
    load_time_req = t;
    load_alarm_req = a;
    tick();
    load_time_req = 1'b0;
    load_alarm_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick();
    n_checks++; if ({a_rs, a_tl, a_al, a_err, a_busy, a_dc, a_lv} !== 24'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {a_rs, a_tl, a_al, a_err, a_busy, a_dc, a_lv}); end
    reset_n = 1'b1;
    repeat (4) tick();
    n_checks++; if ({a_busy, a_dc, a_lv} !== 20'h0) begin n_fail++; $display("FAIL reset_release: got %h want 0", {a_busy, a_dc, a_lv}); end
    send_digit(16'haaa5);
    repeat (2) tick();
    n_checks++; if ({a_busy, a_dc} !== 4'h0) begin n_fail++; $display("FAIL idle_digit_ignored: got %h want 0", {a_busy, a_dc}); end
  endtask

  task automatic test_time_entry();
    logic [15:0] kv;
    request(1'b1, 1'b0);
    n_checks++; if ({a_rs, a_busy, a_dc} !== 5'b11000) begin n_fail++; $display("FAIL t1_arm: got %b want 11000", {a_rs, a_busy, a_dc}); end
    tick();
    n_checks++; if (a_rs !== 1'b0) begin n_fail++; $display("FAIL t1_rs_one_cycle: got %b want 0", a_rs); end
    kv = KEYPAD_BLANK_WORD;
    for (int i = 0; i < 4; i++) begin
      kv = {kv[11:0], 4'(i == 0 ? 2 : i == 1 ? 3 : i == 2 ? 5 : 9)};
      send_digit(kv);
      n_checks++; if (a_dc !== 3'(i)) begin n_fail++; $display("FAIL t1_count_%0d: got %0d want %0d", i, a_dc, i); end
    end
    tick();
    n_checks++; if ({a_dc, a_busy, a_tl} !== 5'b10010) begin n_fail++; $display("FAIL t1_check_cycle: got %b want 10010", {a_dc, a_busy, a_tl}); end
    tick();
    n_checks++; if ({a_tl, a_al, a_rs} !== 3'b101) begin n_fail++; $display("FAIL t1_strobe: got %b want 101", {a_tl, a_al, a_rs}); end
    n_checks++; if (a_lv !== 16'h2359) begin n_fail++; $display("FAIL t1_value: got %h want 2359", a_lv); end
    n_checks++; if ({b_err, b_tl} !== 2'b10) begin n_fail++; $display("FAIL t1_12h_reject: got %b want 10", {b_err, b_tl}); end
    tick();
    n_checks++; if ({a_tl, a_busy, a_lv} !== {2'b00, 16'h2359}) begin n_fail++; $display("FAIL t1_after: got %h want 2359", {a_tl, a_busy, a_lv}); end
  endtask

  task automatic test_alarm_invalid(input logic [15:0] w);
    request(1'b0, 1'b1);
    n_checks++; if (a_rs !== 1'b1) begin n_fail++; $display("FAIL t2_arm_%h: got %b want 1", w, a_rs); end
    enter_digits(w, 4);
    repeat (2) tick();
    n_checks++; if ({a_err, a_al, a_tl, a_rs} !== 4'b1001) begin n_fail++; $display("FAIL t2_error_%h: got %b want 1001", w, {a_err, a_al, a_tl, a_rs}); end
    n_checks++; if (a_lv !== 16'h2359) begin n_fail++; $display("FAIL t2_value_%h: got %h want 2359", w, a_lv); end
    tick();
    n_checks++; if ({a_err, a_busy} !== 2'b00) begin n_fail++; $display("FAIL t2_done_%h: got %b want 00", w, {a_err, a_busy}); end
  endtask

  task automatic test_12h(input logic [15:0] w, input logic ok12, input logic [15:0] lv12);
    request(1'b1, 1'b0);
    enter_digits(w, 4);
    repeat (2) tick();
    n_checks++; if ({b_tl, b_err} !== {ok12, ~ok12}) begin n_fail++; $display("FAIL t3_12h_%h: got %b want %b", w, {b_tl, b_err}, {ok12, ~ok12}); end
    n_checks++; if (b_lv !== lv12) begin n_fail++; $display("FAIL t3_12h_value_%h: got %h want %h", w, b_lv, lv12); end
    n_checks++; if ({a_tl, a_lv} !== {1'b1, w}) begin n_fail++; $display("FAIL t3_24h_%h: got %h want %h", w, {a_tl, a_lv}, {1'b1, w}); end
    tick();
  endtask

  task automatic test_timeout();
    request(1'b1, 1'b0);
    enter_digits(16'h1234, 2);
    repeat (19) tick();
    n_checks++; if ({a_err, a_busy} !== 2'b01) begin n_fail++; $display("FAIL t4_before: got %b want 01", {a_err, a_busy}); end
    tick();
    n_checks++; if ({a_err, a_rs, a_busy, a_dc} !== 6'b111010) begin n_fail++; $display("FAIL t4_timeout: got %b want 111010", {a_err, a_rs, a_busy, a_dc}); end
    tick();
    n_checks++; if ({a_err, a_busy, a_dc} !== 5'b00010) begin n_fail++; $display("FAIL t4_idle: got %b want 00010", {a_err, a_busy, a_dc}); end
  endtask

  task automatic test_cancel();
    request(1'b1, 1'b0);
    enter_digits(16'h1045, 3);
    send_digit(16'h1045);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++; if ({a_rs, a_busy, a_err, a_tl, a_dc} !== 7'b1000011) begin n_fail++; $display("FAIL t5_cancel: got %b want 1000011", {a_rs, a_busy, a_err, a_tl, a_dc}); end
    tick();
    n_checks++; if ({a_tl, a_al, a_err, a_rs, a_busy} !== 5'b0) begin n_fail++; $display("FAIL t5_no_strobe: got %b want 00000", {a_tl, a_al, a_err, a_rs, a_busy}); end
  endtask

  task automatic test_back_to_back();
    logic rs_seen;
    request(1'b1, 1'b1);
    n_checks++; if (a_rs !== 1'b1) begin n_fail++; $display("FAIL t6_arm: got %b want 1", a_rs); end
    send_digit(16'haaa0);
    request(1'b0, 1'b1);
    n_checks++; if ({a_rs, a_busy, a_dc} !== 5'b01001) begin n_fail++; $display("FAIL t6_req_ignored: got %b want 01001", {a_rs, a_busy, a_dc}); end
    send_digit(16'haa08);
    send_digit(16'ha083);
    send_digit(16'h0830);
    repeat (2) tick();
    n_checks++; if ({a_tl, a_al, a_lv} !== {2'b10, 16'h0830}) begin n_fail++; $display("FAIL t6_time_wins: got %h want 20830", {a_tl, a_al, a_lv}); end
    tick();
    request(1'b1, 1'b0);
    send_digit(16'haaa1);
    tick();
    n_checks++; if ({a_busy, a_dc} !== 4'b1001) begin n_fail++; $display("FAIL t6_mid_collect: got %b want 1001", {a_busy, a_dc}); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({a_rs, a_tl, a_al, a_err, a_busy, a_dc, a_lv} !== 24'h0) begin n_fail++; $display("FAIL t6_async_reset: got %h want 0", {a_rs, a_tl, a_al, a_err, a_busy, a_dc, a_lv}); end
    tick();
    reset_n = 1'b1;
    rs_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rs_seen = rs_seen | a_rs | a_tl | a_err;
    end
    n_checks++; if ({rs_seen, a_busy} !== 2'b00) begin n_fail++; $display("FAIL t6_no_pulse_after_reset: got %b want 00", {rs_seen, a_busy}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_time_entry();
    test_alarm_invalid(16'h2460);
    test_alarm_invalid(16'h07a5);
    test_12h(16'h1200, 1'b1, 16'h1200);
    test_12h(16'h0000, 1'b0, 16'h1200);
    test_12h(16'h1300, 1'b0, 16'h1200);
    test_timeout();
    test_cancel();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
